// File: rtl/gda_pkg.sv
// Shared constants, FSM state encoding and carry-window error detection
// for the GDA approximate-adder correction stage.
package gda_pkg;

  localparam int GDA_N  = 8;
  localparam int GDA_P  = 6;
  localparam int GDA_CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIX_LO = 2'd1,
    FIX_HI = 2'd2
  } gda_state_e;

  // True when a generate at bit j-p-1 propagates through p bits into bit j,
  // a carry the upstream prediction window cannot see. Operands are
  // zero-extended to 32 bits so n and p may be any elaboration constants.
  function automatic logic gda_err_detect(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int n,
                                          input int p);
    logic [31:0] g;
    logic [31:0] pv;
    logic [31:0] gs;
    logic [31:0] ps;
    logic        chain;
    logic        err;
    g   = a & b;
    pv  = a ^ b;
    err = 1'b0;
    for (int j = 1; j < 32; j++) begin
      if (j >= p + 1 && j <= n - 1) begin
        gs    = g >> (j - p - 1);
        chain = gs[0];
        for (int k = 0; k < 32; k++) begin
          if (k >= j - p && k <= j - 1) begin
            ps    = pv >> k;
            chain = chain & ps[0];
          end
        end
        err = err | chain;
      end
    end
    return err;
  endfunction

endpackage

// File: rtl/gda_half_ripple.sv
// Combinational W-bit ripple-carry adder; one instance serves both halves
// of the exact recomputation.
module gda_half_ripple #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/gda_err_recovery.sv
// Error-recovery stage after the GDA adder: passes correct approximate sums
// through in one cycle, recomputes missed-carry beats exactly in two halves.
module gda_err_recovery
  import gda_pkg::*;
#(
  parameter int N  = GDA_N,
  parameter int P  = GDA_P,
  parameter int CW = GDA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic [N:0]    approx_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    out_res,
  output logic          out_err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] op_count
);

  localparam int H = N / 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  gda_state_e state, state_nxt;

  logic [N-1:0] a_q, b_q;
  logic [H-1:0] lo_q;
  logic         c_q;
  logic         err, accept, load_fast, load_fix, out_free;
  logic [H-1:0] ha, hb, hsum;
  logic         hcin, hcout;

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; valid never depends on ready, and the producer holds data
  // stable while valid is high and ready is low.
  assign out_free  = !out_valid | out_ready;
  assign in_ready  = rst_n & (state == IDLE) & out_free;
  assign accept    = in_valid & in_ready;
  assign err       = gda_err_detect(32'(in1), 32'(in2), N, P);
  assign load_fast = accept & !err;
  assign load_fix  = (state == FIX_HI) & out_free;

  always_comb begin
    ha   = a_q[H-1:0];
    hb   = b_q[H-1:0];
    hcin = 1'b0;
    if (state == FIX_HI) begin
      ha   = a_q[N-1:H];
      hb   = b_q[N-1:H];
      hcin = c_q;
    end
  end

  gda_half_ripple #(.W(H)) u_ripple (
    .a    (ha),
    .b    (hb),
    .cin  (hcin),
    .sum  (hsum),
    .cout (hcout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && err) state_nxt = FIX_LO;
      FIX_LO:  state_nxt = FIX_HI;
      FIX_HI:  if (load_fix) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      lo_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && err) begin
        a_q <= in1;
        b_q <= in2;
      end
      if (state == FIX_LO) begin
        lo_q <= hsum;
        c_q  <= hcout;
      end
    end
  end

  // Output register; a new result may replace one consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_err   <= 1'b0;
    end else if (load_fast) begin
      out_valid <= 1'b1;
      out_res   <= approx_res;
      out_err   <= 1'b0;
    end else if (load_fix) begin
      out_valid <= 1'b1;
      out_res   <= {hcout, hsum, lo_q};
      out_err   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else begin
      if (accept && op_count != CNT_MAX) op_count <= op_count + 1'b1;
      if (load_fix && err_count != CNT_MAX) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gda_err_recovery.sv
// Bench for gda_err_recovery (N=8, P=6, CW=4): vector table, hand-written
// latency/backpressure/reset sequences and a random-backpressure phase.
module tb_gda_err_recovery;

  localparam int N    = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [N-1:0]  in1, in2;
  logic [N:0]    approx_res, out_res;
  logic [CW-1:0] err_count, op_count;

  always #5 clk = ~clk;

  gda_err_recovery #(.N(N), .P(6), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .approx_res (approx_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_err    (out_err),
    .err_count  (err_count),
    .op_count   (op_count)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] ap;
    logic [8:0] res;
    logic       err;
  } vec_t;

  vec_t       vecs[10];
  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         op_m = 0;
  int         err_m = 0;
  bit         bp_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic [7:0] a, input logic [7:0] b);
    return (a[0] & b[0]) & (&(a[6:1] ^ b[6:1]));
  endfunction

  // Scoreboard: one pop per output transfer.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected none", out_res);
        end else begin
          e = exp_q.pop_front();
          check("out_res", int'(out_res), int'(e[9:1]));
          check("out_err", int'(out_err), int'(e[0]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap,
                      input logic [9:0] exp, output int waited);
    in1 = a;
    in2 = b;
    approx_res = ap;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      if (op_m < CMAX) op_m++;
      if (exp[0] && err_m < CMAX) err_m++;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] exact;
    logic       e;
    int         w;
    exact = {1'b0, a} + {1'b0, b};
    e = model_err(a, b);
    send(a, b, e ? (exact ^ 9'h080) : exact, {exact, e}, w);
  endtask

  task automatic send_err_rand();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom_range(0, 255)) | 8'h01;
    b = {1'($urandom_range(0, 1)), ~a[6:1], 1'b1};
    send_op(a, b);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_op_count"}, int'(op_count), op_m);
    check({tag, "_err_count"}, int'(err_count), err_m);
  endtask

  initial begin
    int w;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    approx_res = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_res", int'(out_res), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check_counts("rst");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    // Error-free beat: one-cycle latency.
    send(8'h0F, 8'h01, 9'h010, {9'h010, 1'b0}, w);
    check("fast_latency_valid", int'(out_valid), 1);
    check("fast_res", int'(out_res), 'h010);
    check_counts("fast");
    drain();

    // Missed-carry beat: in_ready low two cycles, result three cycles after accept.
    send(8'h01, 8'h7F, 9'h000, {9'h080, 1'b1}, w);
    check("fix_c1_in_ready", int'(in_ready), 0);
    check("fix_c1_valid", int'(out_valid), 0);
    @(negedge clk);
    check("fix_c2_in_ready", int'(in_ready), 0);
    check("fix_c2_valid", int'(out_valid), 0);
    @(negedge clk);
    check("fix_c3_valid", int'(out_valid), 1);
    check("fix_res", int'(out_res), 'h080);
    check("fix_err", int'(out_err), 1);
    check_counts("fix");
    drain();

    // Corrected result held under backpressure; no input accepted.
    set_ready(1'b0);
    send(8'h01, 8'h7F, 9'h000, {9'h080, 1'b1}, w);
    repeat (2) @(negedge clk);
    in1 = 8'h0F;
    in2 = 8'h01;
    approx_res = 9'h010;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_res", int'(out_res), 'h080);
      check("hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_counts("hold");
    set_ready(1'b1);
    @(negedge clk);
    check("release_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    check("release_pending", exp_q.size(), 0);

    // Back-to-back error-free beats at one per cycle.
    for (int i = 0; i < 3; i++) begin
      send(8'hFF, 8'hFF, 9'h1FE, {9'h1FE, 1'b0}, w);
      check("throughput_wait", w, 0);
    end
    drain();
    check_counts("thru");

    vecs[0] = '{8'h0F, 8'h01, 9'h010, 9'h010, 1'b0};
    vecs[1] = '{8'h01, 8'h7F, 9'h000, 9'h080, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 9'h1FE, 9'h1FE, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 9'h000, 9'h000, 1'b0};
    vecs[4] = '{8'h03, 8'h7D, 9'h000, 9'h080, 1'b1};
    vecs[5] = '{8'h81, 8'hFF, 9'h100, 9'h180, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 9'h0FF, 9'h0FF, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 9'h000, 9'h080, 1'b1};
    vecs[8] = '{8'h01, 8'h3F, 9'h040, 9'h040, 1'b0};
    vecs[9] = '{8'hC1, 8'hBF, 9'h100, 9'h180, 1'b1};
    for (int i = 0; i < 10; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].ap, {vecs[i].res, vecs[i].err}, w);
    drain();
    check_counts("table");

    // Asynchronous reset during FIX_LO discards the in-flight fix.
    send(8'h01, 8'h7F, 9'h000, {9'h080, 1'b1}, w);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    op_m = 0;
    err_m = 0;
    check("arst_valid", int'(out_valid), 0);
    check("arst_res", int'(out_res), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check_counts("arst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_spurious", int'(out_valid), 0);
    end
    check("arst_in_ready_after", int'(in_ready), 1);

    // Random operands under random backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) send_err_rand();
      else send_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    bp_mode = 1'b0;
    set_ready(1'b1);
    drain();
    check_counts("random");

    // Counter saturation at 2^CW-1 while results stay exact.
    for (int i = 0; i < 20; i++) send_err_rand();
    drain();
    check("sat_err_count", int'(err_count), CMAX);
    check("sat_op_count", int'(op_count), CMAX);
    send_op(8'h01, 8'h7F);
    drain();
    check_counts("sat_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gda_err_recovery.md
Name: gda_err_recovery

Overview:
- Registered stage directly downstream of the GDA approximate adder (N=8, M=8, P=6 configuration).
- Consumes the operands and the approximate sum, detects the carry-chain patterns the prediction window misses, and recomputes the exact sum over two extra cycles when needed.
- Presents the final sum on a valid/ready interface to the consumer.
- Keeps error and operation counters for accuracy characterization.

Parameters:
- N, 8, operand width (even, >= 4).
- P, 6, carry-prediction window of the upstream adder (1 <= P <= N-2).
- CW, 16, counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/approx-sum beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in1  in  N  operand A.
- in2  in  N  operand B.
- approx_res  in  N+1  approximate sum from the GDA adder.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  N+1  final sum, always exact.
- out_err  out  1  result required correction.
- err_count  out  CW  saturating count of corrected beats.
- op_count  out  CW  saturating count of accepted beats.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; out_res=0; out_err=0; err_count=0; op_count=0; in_ready=0 while in reset. Any in-flight fix is discarded.
- Per-bit signals: g[i]=in1[i]&in2[i], p[i]=in1[i]^in2[i].
- Error detect (combinational on the input beat): err = OR over j=P+1..N-1 of ( g[j-P-1] & AND(p[j-P..j-1]) ). For N=8, P=6 this is g0&p1&...&p6.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, op_count increments (saturating at 2^CW-1).
- States:
  - IDLE, accept with err=0: next cycle out_valid=1, out_res=approx_res, out_err=0. Latency 1.
  - IDLE, accept with err=1: latch in1/in2 and go to FIX_LO. approx_res is ignored.
  - FIX_LO: ripple-add the low N/2 bits with carry-in 0; register the partial sum and carry. Go to FIX_HI.
  - FIX_HI: add the upper N/2 bits plus the stored carry. Load out_res={carry_out, hi, lo}, out_err=1, out_valid=1; err_count increments (saturating). Go to IDLE. Accept-to-out_valid latency is 3.
- Output register:
  - Holds while out_valid & !out_ready.
  - Clears out_valid on out_ready when no new result is loaded in the same cycle.
  - A new result may load in the same cycle the old one is consumed (full throughput for error-free beats).
- FIX_HI load is stalled while out_valid & !out_ready: remain in FIX_HI until the register frees.
- in_ready=0 in FIX_LO/FIX_HI, so there is no input during correction.
- Arithmetic is unsigned, N+1-bit result, with no wrap beyond bit N.
- in1/in2/approx_res are don't-care when in_valid=0.
- The upstream adder is not instantiated in this block.

Decomposition:
- Shared package gda_pkg:
  - default N, P, CW constants.
  - function gda_err_detect(in1,in2,N,P).
  - state enum {IDLE, FIX_LO, FIX_HI}.
- One sub-module: gda_half_ripple. A parameterized N/2-bit ripple adder with carry-in/out, reused for the LO and HI cycles.

Test Plan:
- 0x0F+0x01, approx_res=0x010, out_ready=1 -> out_valid one cycle after accept, out_res=0x010, out_err=0, op_count=1, err_count=0.
- 0x01+0x7F, approx_res=0x000 -> err detected, in_ready low 2 cycles, out_valid 3 cycles after accept, out_res=0x080, out_err=1, err_count=1.
- 0xFF+0xFF, approx_res=0x1FE -> no error (p1..p6=0), out_res=0x1FE in 1 cycle. Back-to-back error-free beats sustain 1 beat/cycle.
- Error beat with out_ready=0 for 5 cycles after FIX_HI -> stays in FIX_HI/holds, out_res stable at 0x080, no input accepted. Release -> one transfer, then in_ready=1.
- rst_n pulsed low during FIX_LO -> outputs/counters zero immediately (async). After release, IDLE with in_ready=1 and no spurious out_valid.
- CW=4: 20 error beats -> err_count saturates at 15, op_count at 15. Later beats still produce exact results.
